// File: rtl/frame_bram_ctrl.sv
// Single-frame pixel buffer: raster fill, 1-cycle random-address scan reads, zero-pad tail, then finish.
// Optional read range check enabled by defining FRAME_BRAM_ADDR_CHECK_EN (drives addr_err).
module frame_bram_ctrl #(
    parameter int DATA_W  = 1,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int PAD_LEN = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_count,
    output logic              frame_full,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              end_scale,
    output logic              pad_active,
    output logic              finish,
    input  logic              frame_clear,
    output logic              addr_err
);

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        PAD_LAST  = 8'(PAD_LEN - 1);

    typedef enum logic [1:0] {FILL, SCAN, PAD, DONE} state_t;

    state_t            state;
    logic [7:0]        pad_cnt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign wr_ready   = (state == FILL);
    assign pad_active = (state == PAD);

`ifdef FRAME_BRAM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    logic out_rng;
    assign out_rng = ({1'b0, rd_addr} >= DEPTH_X);
`else
    // Upper address bits beyond the storage index are deliberately unused here.
    logic rd_addr_unused;
    assign rd_addr_unused = ^rd_addr;
`endif

    // Write port kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && !frame_clear && wr_ready && wr_valid)
            mem[wr_count[IDX_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (PAD_LEN >= 1 && PAD_LEN <= 255);
        if (rst) begin
            state      <= FILL;
            wr_count   <= '0;
            frame_full <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            finish     <= 1'b0;
            pad_cnt    <= '0;
            addr_err   <= 1'b0;
        end else if (frame_clear) begin
            state      <= FILL;
            wr_count   <= '0;
            frame_full <= 1'b0;
            rd_valid   <= 1'b0;
            finish     <= 1'b0;
            pad_cnt    <= '0;
            addr_err   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    rd_valid <= 1'b0;
                    if (wr_valid) begin
                        wr_count <= wr_count + ADDR_W'(1);
                        if (wr_count == LAST_ADDR) begin
                            frame_full <= 1'b1;
                            state      <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (end_scale) begin
                        // A read arriving with end_scale is dropped.
                        state    <= PAD;
                        pad_cnt  <= '0;
                        rd_valid <= 1'b0;
                    end else if (rd_en) begin
                        rd_valid <= 1'b1;
`ifdef FRAME_BRAM_ADDR_CHECK_EN
                        if (out_rng) begin
                            rd_data  <= '0;
                            addr_err <= 1'b1;
                        end else
`endif
                            rd_data <= mem[rd_addr[IDX_W-1:0]];
                    end else begin
                        rd_valid <= 1'b0;
                    end
                end
                PAD: begin
                    rd_valid <= 1'b1;
                    rd_data  <= '0;
                    pad_cnt  <= pad_cnt + 8'd1;
                    if (pad_cnt == PAD_LAST) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    rd_valid <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_bram_ctrl.sv
// Directed/randomized bench for frame_bram_ctrl at 4x4 frame, 8-bit pixels, 3-pixel pad.
module tb_frame_bram_ctrl;

    localparam int DATA_W  = 8;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int ADDR_W  = 5;
    localparam int PAD_LEN = 3;
    localparam int DEPTH   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst, wr_valid, wr_ready, frame_full, rd_en, rd_valid;
    logic              end_scale, pad_active, finish, frame_clear, addr_err;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [ADDR_W-1:0] wr_count, rd_addr;

    int total = 0;
    int bad   = 0;
    int model_cnt;
    logic [DATA_W-1:0] model_mem [0:DEPTH-1];

    always #5 clk = ~clk;

    frame_bram_ctrl #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PAD_LEN(PAD_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_count(wr_count), .frame_full(frame_full),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .end_scale(end_scale), .pad_active(pad_active), .finish(finish),
        .frame_clear(frame_clear), .addr_err(addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_data = '0; rd_en = 0; rd_addr = '0;
        end_scale = 0; frame_clear = 0;
    endtask

    // Streams one frame; on odd cycles wr_valid is dropped when toggle is set.
    task automatic fill_frame(input bit toggle, input bit incr, input logic [DATA_W-1:0] base);
        int cyc = 0;
        model_cnt = 0;
        while (model_cnt < DEPTH && cyc < 200) begin
            wr_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            wr_data  = incr ? base + DATA_W'(model_cnt) : DATA_W'($urandom);
            rd_en    = 1'($urandom);
            rd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            chk("fill_wr_ready", wr_ready, 1);
            tick();
            if (wr_valid) begin
                model_mem[model_cnt] = wr_data;
                model_cnt++;
            end
            chk("fill_wr_count", wr_count, model_cnt);
            chk("fill_rd_valid", rd_valid, 0);
            cyc++;
        end
        if (model_cnt < DEPTH) chk("fill_timeout", model_cnt, DEPTH);
        idle_inputs();
        chk("full_wr_ready", wr_ready, 0);
        chk("full_flag", frame_full, 1);
        chk("full_count", wr_count, DEPTH);
    endtask

    task automatic read_px(input int a);
        rd_en = 1; rd_addr = ADDR_W'(a);
        tick();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, model_mem[a]);
    endtask

    task automatic pad_sequence();
        for (int k = 1; k <= PAD_LEN; k++) begin
            rd_en = 1'($urandom); rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
            chk("pad_valid", rd_valid, 1);
            chk("pad_zero", rd_data, 0);
            chk("pad_finish", finish, (k == PAD_LEN));
            chk("pad_active", pad_active, (k < PAD_LEN));
        end
        rd_en = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_full", frame_full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pad_active", pad_active, 0);
        chk("rst_finish", finish, 0);
        chk("rst_addr_err", addr_err, 0);
        rst = 0;

        // 1: incrementing fill, then a 17th write attempt is ignored
        fill_frame(0, 1, 8'h10);
        wr_valid = 1; wr_data = 8'hAA;
        tick();
        wr_valid = 0;
        chk("extra_write_count", wr_count, DEPTH);
        chk("extra_write_full", frame_full, 1);

        // 2: back-to-back reads, fixed then random addresses
        read_px(0); read_px(5); read_px(15);
        for (int i = 0; i < 8; i++) read_px($urandom_range(0, DEPTH - 1));
        rd_en = 0;
        tick();
        chk("rd_idle", rd_valid, 0);

        // 3: end_scale with a coincident read; read dropped, pad follows
        end_scale = 1; rd_en = 1; rd_addr = 5'd3;
        tick();
        end_scale = 0; rd_en = 0;
        chk("drop_rd_valid", rd_valid, 0);
        chk("enter_pad", pad_active, 1);
        pad_sequence();
        for (int i = 0; i < 10; i++) begin
            end_scale = 1'($urandom); rd_en = 1'($urandom);
            tick();
            chk("done_finish", finish, 1);
            chk("done_rd_valid", rd_valid, 0);
        end
        idle_inputs();

        // 4: clear from DONE, refill with gapped wr_valid, full random readback
        frame_clear = 1;
        tick();
        frame_clear = 0;
        chk("clr_finish", finish, 0);
        chk("clr_count", wr_count, 0);
        chk("clr_full", frame_full, 0);
        fill_frame(1, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) read_px((i * 7 + 3) % DEPTH);
        rd_en = 0;

        // 5: clear mid-pad after one zero; clear wins over a same-cycle write
        end_scale = 1;
        tick();
        end_scale = 0;
        tick();
        chk("pad1_valid", rd_valid, 1);
        frame_clear = 1;
        tick();
        chk("midpad_rd_valid", rd_valid, 0);
        chk("midpad_finish", finish, 0);
        chk("midpad_count", wr_count, 0);
        chk("midpad_fill", wr_ready, 1);
        chk("midpad_pad_off", pad_active, 0);
        wr_valid = 1; wr_data = 8'hEE;
        tick();
        frame_clear = 0; wr_valid = 0;
        chk("clr_blocks_write", wr_count, 0);
        fill_frame(0, 1, 8'h20);
        read_px(0); read_px(15); read_px(9);
        rd_en = 0;

        // 6: out-of-range read
        rd_en = 1; rd_addr = 5'd16;
        tick();
        rd_en = 0;
        chk("oor_rd_valid", rd_valid, 1);
`ifdef FRAME_BRAM_ADDR_CHECK_EN
        chk("oor_rd_data", rd_data, 0);
        chk("oor_addr_err", addr_err, 1);
        read_px(4);
        chk("addr_err_sticky", addr_err, 1);
`else
        chk("oor_no_err", addr_err, 0);
        read_px(4);
        chk("addr_err_tied", addr_err, 0);
`endif
        // mid-operation reset discards the pending read output
        rd_en = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst2_addr_err", addr_err, 0);
        chk("rst2_rd_data", rd_data, 0);
        chk("rst2_rd_valid", rd_valid, 0);
        chk("rst2_count", wr_count, 0);
        chk("rst2_wr_ready", wr_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
